// File: rtl/down_timer.sv
// Loadable down-counter with start/pause control, one-shot or auto-reload expiry,
// and an error pulse when started with nothing to count.
module down_timer #(
  parameter int CW     = 16,
  parameter bit RELOAD = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  input  logic          i_start,
  input  logic          i_stop,
  output logic [CW-1:0] o_count,
  output logic          o_busy,
  output logic          o_expired,
  output logic          o_err,
  output logic [1:0]    o_state
);

  // Handshake: all inputs are single-cycle level strobes sampled on the rising
  // edge; priority is i_load > i_stop > i_start; no ready/acknowledge is returned.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e        state_q   = IDLE;
  state_e        state_d;
  logic [CW-1:0] count_q   = '0;
  logic [CW-1:0] count_d;
  logic [CW-1:0] reload_q  = '0;
  logic [CW-1:0] reload_d;
  logic          expired_q = 1'b0;
  logic          expired_d;
  logic          err_q     = 1'b0;
  logic          err_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    err_d     = 1'b0;

    if (i_load) begin
      count_d  = i_value;
      reload_d = i_value;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A stop in the same cycle outranks start even though it does nothing here.
          if (!i_stop && i_start) begin
            if (count_q != '0) state_d = RUN;
            else               err_d   = 1'b1;
          end
        end
        RUN: begin
          if (i_stop) begin
            state_d = PAUSE;
          end else if (count_q == CW'(1)) begin
            expired_d = 1'b1;
            if (RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else if (count_q == '0) begin
            // Unreachable in normal use; park safely rather than wrap.
            state_d = IDLE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
        PAUSE: begin
          if (!i_stop && i_start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_count   = count_q;
  assign o_busy    = (state_q == RUN);
  assign o_expired = expired_q;
  assign o_err     = err_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: one-shot and auto-reload instances share stimulus and
// are compared every cycle against a behavioural model of the timer rules.
module tb_down_timer;
  localparam int CW  = 16;
  localparam int MOD = 65536;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_load = 1'b0;
  logic [CW-1:0] i_value = '0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;

  logic [CW-1:0] cnt0, cnt1;
  logic          busy0, busy1, exp0, exp1, err0, err1;
  logic [1:0]    st0, st1;

  down_timer #(.CW(CW), .RELOAD(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_value(i_value),
    .i_start(i_start), .i_stop(i_stop), .o_count(cnt0), .o_busy(busy0),
    .o_expired(exp0), .o_err(err0), .o_state(st0)
  );

  down_timer #(.CW(CW), .RELOAD(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_value(i_value),
    .i_start(i_start), .i_stop(i_stop), .o_count(cnt1), .o_busy(busy1),
    .o_expired(exp1), .o_err(err1), .o_state(st1)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Model: index 0 = one-shot, 1 = auto-reload. running/paused flags instead of a state code.
  int m_count[2];
  int m_reload[2];
  bit m_running[2];
  bit m_paused[2];
  bit m_exp[2];
  bit m_err[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0; m_reload[k] = 0;
      m_running[k] = 0; m_paused[k] = 0;
      m_exp[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input int v, input bit st, input bit sp);
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 0;
      m_err[k] = 0;
      if (rst) begin
        m_count[k] = 0; m_reload[k] = 0; m_running[k] = 0; m_paused[k] = 0;
      end else if (ld) begin
        m_count[k] = v; m_reload[k] = v; m_running[k] = 0; m_paused[k] = 0;
      end else if (m_running[k]) begin
        if (sp) begin
          m_running[k] = 0; m_paused[k] = 1;
        end else if (m_count[k] == 1) begin
          m_exp[k] = 1;
          if (k == 1) m_count[k] = m_reload[k];
          else begin m_count[k] = 0; m_running[k] = 0; end
        end else begin
          m_count[k] = (m_count[k] + MOD - 1) % MOD;
        end
      end else if (!sp && st) begin
        if (m_paused[k]) begin
          m_paused[k] = 0; m_running[k] = 1;
        end else if (m_count[k] != 0) begin
          m_running[k] = 1;
        end else begin
          m_err[k] = 1;
        end
      end
    end
  endtask

  task automatic compare(input string ph);
    check({ph, "/cnt0"},  cnt0,  m_count[0]);
    check({ph, "/busy0"}, busy0, m_running[0]);
    check({ph, "/exp0"},  exp0,  m_exp[0]);
    check({ph, "/err0"},  err0,  m_err[0]);
    check({ph, "/cnt1"},  cnt1,  m_count[1]);
    check({ph, "/busy1"}, busy1, m_running[1]);
    check({ph, "/exp1"},  exp1,  m_exp[1]);
    check({ph, "/err1"},  err1,  m_err[1]);
  endtask

  task automatic step(input string ph, input bit rst, input bit ld, input int v,
                      input bit st, input bit sp);
    i_rst = rst; i_load = ld; i_value = CW'(v); i_start = st; i_stop = sp;
    @(posedge i_clk);
    model_edge(rst, ld, v, st, sp);
    #1;
    compare(ph);
    i_rst = 0; i_load = 0; i_start = 0; i_stop = 0;
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    compare("powerup");
    step("reset", 1, 0, 0, 0, 0);

    // One-shot 5,4,3,2,1,0 (auto-reload instance runs alongside).
    step("os_load", 0, 1, 5, 0, 0);
    step("os_start", 0, 0, 0, 1, 0);
    idle("os_run", 5);
    check("os_final_cnt", cnt0, 0);
    check("os_final_exp", exp0, 1);
    check("os_final_busy", busy0, 0);
    idle("os_after", 2);

    // Auto-reload period 3, then period 1.
    step("ar_load", 0, 1, 3, 0, 0);
    step("ar_start", 0, 0, 0, 1, 0);
    idle("ar_run", 10);
    check("ar_busy", busy1, 1);
    step("ar1_load", 0, 1, 1, 0, 0);
    step("ar1_start", 0, 0, 0, 1, 0);
    idle("ar1_run", 4);
    check("ar1_exp", exp1, 1);

    // Pause/resume.
    step("pr_load", 0, 1, 10, 0, 0);
    step("pr_start", 0, 0, 0, 1, 0);
    idle("pr_run", 4);
    step("pr_stop", 0, 0, 0, 0, 1);
    idle("pr_hold", 5);
    check("pr_hold_cnt", cnt0, 6);
    step("pr_stop_again", 0, 0, 0, 0, 1);
    step("pr_resume", 0, 0, 0, 1, 0);
    idle("pr_run2", 3);

    // Zero start.
    step("zs_reset", 1, 0, 0, 0, 0);
    step("zs_start", 0, 0, 0, 1, 0);
    check("zs_err", err0, 1);
    idle("zs_after", 2);

    // Strobe priority mid-run.
    step("pri_load", 0, 1, 7, 0, 0);
    step("pri_start", 0, 0, 0, 1, 0);
    idle("pri_run", 2);
    step("pri_all", 0, 1, 2, 1, 1);
    check("pri_cnt", cnt0, 2);
    idle("pri_after", 2);

    // Load coinciding with expiry cycle.
    step("le_start", 0, 0, 0, 1, 0);
    step("le_run", 0, 0, 0, 0, 0);
    step("le_load", 0, 1, 4, 0, 0);
    check("le_noexp", exp0, 0);

    // Maximum value, reset mid-run, and reset mid-pause.
    step("max_load", 0, 1, MOD - 1, 0, 0);
    step("max_start", 0, 0, 0, 1, 0);
    idle("max_run", 100);
    check("max_cnt", cnt0, MOD - 101);
    step("max_reset", 1, 0, 0, 1, 0);
    step("mp_load", 0, 1, 9, 0, 0);
    step("mp_start", 0, 0, 0, 1, 0);
    step("mp_stop", 0, 0, 0, 0, 1);
    step("mp_reset", 1, 1, 5, 1, 1);

    // Randomized strobes.
    for (int i = 0; i < 3000; i++) begin
      int r, v;
      bit rst, ld, st, sp;
      r = $urandom_range(0, 99);
      rst = (r < 1);
      ld = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 20);
      sp = ($urandom_range(0, 99) < 8);
      r = $urandom_range(0, 9);
      if (r == 0) v = 0;
      else if (r == 1) v = MOD - 1;
      else if (r == 2) v = $urandom_range(0, MOD - 1);
      else v = $urandom_range(1, 8);
      step("rand", rst, ld, v, st, sp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
